// File: rtl/en2falling_pulse_if.sv
// Request/pulse-line bundle for the falling-edge signalling transmitter.
// The master drives requests; the slave (transmitter) drives the line and its status.
interface en2falling_pulse_if #(
    parameter int PEND_W = 2
);
    logic              en;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pend;
    logic              ovf;

    modport master (output en, input out, busy, pend, ovf);
    modport slave  (input en, output out, busy, pend, ovf);
endinterface

// File: rtl/en2falling_pulse.sv
// Turns 1-cycle enable requests into active-low pulses with guaranteed low/high
// widths, queueing requests that arrive while a pulse is in flight.
module en2falling_pulse #(
    parameter int LOW_CYC = 4,
    parameter int GAP_CYC = 4,
    parameter int PEND_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    en2falling_pulse_if.slave    bus
);
    localparam int MAX_CYC = (LOW_CYC > GAP_CYC) ? LOW_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, LOW, GAP} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [PEND_W-1:0]   pend, pend_n;
    logic                out, out_n;
    logic                ovf, ovf_n;
    logic                pend_nz, last_low, last_gap, launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            out   <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            out   <= out_n;
            ovf   <= ovf_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pend_n   = pend;
        ovf_n    = 1'b0;
        pend_nz  = (pend != '0);
        last_low = (state == LOW) && (cnt == CNT_W'(LOW_CYC - 1));
        last_gap = (state == GAP) && (cnt == CNT_W'(GAP_CYC - 1));
        // The last GAP cycle may relaunch directly, giving an exact LOW+GAP period.
        launch   = ((state == IDLE) || last_gap) && (bus.en || pend_nz);

        case (state)
            LOW: begin
                if (last_low) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (last_gap) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: ;
        endcase

        if (launch) begin
            state_n = LOW;
            cnt_n   = '0;
        end

        // Queued requests launch first; a simultaneous en then takes its queue slot.
        if (launch && pend_nz && !bus.en) begin
            pend_n = pend - 1'b1;
        end else if (!launch && bus.en) begin
            if (pend != '1) pend_n = pend + 1'b1;
            else            ovf_n  = 1'b1;
        end

        out_n = (state_n != LOW);
    end

    assign bus.out  = out;
    assign bus.pend = pend;
    assign bus.ovf  = ovf;
    assign bus.busy = (state != IDLE) || pend_nz;
endmodule

// File: tb/tb_en2falling_pulse.sv
// Directed, table-driven bench for en2falling_pulse (4/4/2) plus a 1/1/2 instance
// for the fastest-toggle case.
module tb_en2falling_pulse;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    en2falling_pulse_if #(.PEND_W(2)) ifa ();
    en2falling_pulse_if #(.PEND_W(2)) ifb ();

    en2falling_pulse #(.LOW_CYC(4), .GAP_CYC(4), .PEND_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    en2falling_pulse #(.LOW_CYC(1), .GAP_CYC(1), .PEND_W(2)) dut_fast (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    typedef struct packed {
        logic       en;
        logic       out;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    function automatic void add(input int unsigned n, input logic en, input logic out,
                                input logic busy, input logic [1:0] pend, input logic ovf);
        vec_t v;
        v.en = en; v.out = out; v.busy = busy; v.pend = pend; v.ovf = ovf;
        for (int unsigned k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    function automatic void check(input string name, input int idx,
                                  input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s @%0d: got %0h expected %0h", name, idx, got, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned bad;
        int unsigned ovf_cnt;
        int unsigned edges;
        int unsigned budget;
        logic prev;

        // 1: single request
        add(1, 1, 1, 0, 0, 0); add(4, 0, 0, 1, 0, 0); add(4, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 0);
        // 2: requests at 10 and 12
        add(1, 1, 1, 0, 0, 0); add(1, 0, 0, 1, 0, 0); add(1, 1, 0, 1, 0, 0);
        add(2, 0, 0, 1, 1, 0); add(4, 0, 1, 1, 1, 0);
        add(4, 0, 0, 1, 0, 0); add(4, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 0);
        // 3: five back-to-back requests, queue saturates, fifth dropped
        add(1, 1, 1, 0, 0, 0); add(1, 1, 0, 1, 0, 0); add(1, 1, 0, 1, 1, 0);
        add(1, 1, 0, 1, 2, 0); add(1, 1, 0, 1, 3, 0);
        add(1, 0, 1, 1, 3, 1); add(3, 0, 1, 1, 3, 0);
        add(4, 0, 0, 1, 2, 0); add(4, 0, 1, 1, 2, 0);
        add(4, 0, 0, 1, 1, 0); add(4, 0, 1, 1, 1, 0);
        add(4, 0, 0, 1, 0, 0); add(4, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 0);
        // 4: request on the last GAP cycle relaunches with no idle cycle
        add(1, 1, 1, 0, 0, 0); add(4, 0, 0, 1, 0, 0); add(3, 0, 1, 1, 0, 0);
        add(1, 1, 1, 1, 0, 0); add(4, 0, 0, 1, 0, 0); add(4, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 0);

        rst_n  = 1'b0;
        ifa.en = 1'b0;
        ifb.en = 1'b0;
        repeat (2) tick();
        check("rst_out",  0, 32'(ifa.out),  1);
        check("rst_busy", 0, 32'(ifa.busy), 0);
        check("rst_pend", 0, 32'(ifa.pend), 0);
        check("rst_ovf",  0, 32'(ifa.ovf),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            check("out",  i, 32'(ifa.out),  32'(vecs[i].out));
            check("busy", i, 32'(ifa.busy), 32'(vecs[i].busy));
            check("pend", i, 32'(ifa.pend), 32'(vecs[i].pend));
            check("ovf",  i, 32'(ifa.ovf),  32'(vecs[i].ovf));
            ifa.en = vecs[i].en;
        end
        tick();
        ifa.en = 1'b0;

        // 5: reset mid-LOW with two requests queued
        tick(); ifa.en = 1'b1;
        tick(); ifa.en = 1'b1;
        tick(); check("t5_pend12", 12, 32'(ifa.pend), 1); ifa.en = 1'b1;
        tick();
        check("t5_out13",  13, 32'(ifa.out),  0);
        check("t5_pend13", 13, 32'(ifa.pend), 2);
        ifa.en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_out",  13, 32'(ifa.out),  1);
        check("t5_rst_pend", 13, 32'(ifa.pend), 0);
        check("t5_rst_busy", 13, 32'(ifa.busy), 0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (ifa.out !== 1'b1 || ifa.busy !== 1'b0) bad++;
        end
        check("t5_quiet", 0, bad, 0);

        // 6: LOW=GAP=1, en held 20 cycles
        tick();
        ifb.en  = 1'b1;
        ovf_cnt = 0;
        edges   = 0;
        prev    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("t6_out", k, 32'(ifb.out), (k % 2 == 1) ? 0 : 1);
            if (ifb.ovf === 1'b1) ovf_cnt++;
            if (prev === 1'b1 && ifb.out === 1'b0) edges++;
            prev = ifb.out;
            if (k == 20) ifb.en = 1'b0;
        end
        budget = 0;
        while (ifb.busy !== 1'b0 && budget < 100) begin
            tick();
            budget++;
            if (ifb.ovf === 1'b1) ovf_cnt++;
            if (prev === 1'b1 && ifb.out === 1'b0) edges++;
            prev = ifb.out;
        end
        check("t6_drain", 0, 32'(ifb.busy), 0);
        check("t6_ovf",   0, ovf_cnt, 7);
        check("t6_edges", 0, edges, 13);
        check("t6_edges_vs_accepted", 0, edges, 20 - ovf_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
